// File: rtl/ct_ciu_burst_arb_pkg.sv
// Shared definitions for the CIU burst arbiter: FSM encodings and
// default sizing used by the arbiter top and its testbenches.
package ct_ciu_burst_arb_pkg;

   // Arbiter FSM: IDLE arbitrates per burst, LOCK follows one requester.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   localparam int CIU_NUM_DEF  = 4;
   localparam int CIU_MAXB_DEF = 16;

   // Width of a counter that must be able to hold the value maxb.
   function automatic int cnt_width(input int maxb);
      return (maxb < 1) ? 1 : $clog2(maxb + 1);
   endfunction

endpackage

// File: rtl/ct_prio.sv
// Least-recently-granted priority matrix.
// pri_reg[i][j] = 1 means requester i currently beats requester j.
// A one-hot clr moves that requester to the lowest priority.
module ct_prio #(
   parameter int NUM = 4
) (
   input  logic           clk,
   input  logic           rst_b,
   input  logic [NUM-1:0] valid,
   input  logic [NUM-1:0] clr,
   output logic [NUM-1:0] grant
);

   logic [NUM-1:0][NUM-1:0] pri_reg;
   logic [NUM-1:0][NUM-1:0] beats_me;

   // Matrix update: reset to index order, demote the cleared requester.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < NUM; i++) begin
            for (int j = 0; j < NUM; j++) begin
               pri_reg[i][j] <= (i < j);
            end
         end
      end else if (|clr) begin
         for (int i = 0; i < NUM; i++) begin
            for (int j = 0; j < NUM; j++) begin
               if (clr[i]) begin
                  pri_reg[i][j] <= 1'b0;
               end else if (clr[j]) begin
                  pri_reg[i][j] <= 1'b1;
               end
            end
         end
      end
   end

   // A requester wins when no other valid requester beats it.
   // The diagonal is always 0, so no self-exclusion is needed.
   generate
      for (genvar gi = 0; gi < NUM; gi++) begin : g_grant
         for (genvar gj = 0; gj < NUM; gj++) begin : g_col
            assign beats_me[gi][gj] = pri_reg[gj][gi];
         end
         assign grant[gi] = valid[gi] & ~(|(valid & beats_me[gi]));
      end
   endgenerate

endmodule

// File: rtl/ct_ciu_burst_arb.sv
// Burst arbiter: picks a requester by LRU at the first beat, then locks
// onto it until its last beat. Flags bursts that run past MAXB beats.
module ct_ciu_burst_arb
   import ct_ciu_burst_arb_pkg::*;
#(
   parameter int NUM  = CIU_NUM_DEF,
   parameter int DW   = 64,
   parameter int MAXB = CIU_MAXB_DEF
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [NUM-1:0]    req_vld,
   input  logic [NUM-1:0]    req_last,
   input  logic [NUM*DW-1:0] req_data,
   output logic [NUM-1:0]    req_rdy,
   output logic              out_vld,
   output logic              out_last,
   output logic [DW-1:0]     out_data,
   output logic [NUM-1:0]    out_src,
   input  logic              out_rdy,
   output logic              lock_err
);

   localparam int            IDW    = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int            CW     = cnt_width(MAXB);
   localparam logic [CW-1:0] MAXB_C = CW'(MAXB);

   arb_state_e              state_reg;
   arb_state_e              state_next;
   logic [IDW-1:0]          lock_id_reg;
   logic [CW-1:0]           beat_cnt_reg;
   logic                    lock_err_reg;

   logic [NUM-1:0]          prio_vld;
   logic [NUM-1:0]          prio_clr;
   logic [NUM-1:0]          grant_idle;
   logic [IDW-1:0]          grant_idx;
   logic [NUM-1:0]          lock_oh;
   logic [NUM-1:0]          src_oh;
   logic [NUM-1:0][DW-1:0]  data_masked;
   logic [DW-1:0]           sel_data;
   logic                    sel_vld;
   logic                    sel_last;
   logic                    xfer;

   // The matrix only sees requests while idle and only learns from first beats.
   assign prio_vld = (state_reg == ST_IDLE) ? req_vld : '0;
   assign prio_clr = ((state_reg == ST_IDLE) && xfer) ? src_oh : '0;

   ct_prio #(
      .NUM (NUM)
   ) u_prio (
      .clk   (clk),
      .rst_b (rst_b),
      .valid (prio_vld),
      .clr   (prio_clr),
      .grant (grant_idle)
   );

   // Source select: LRU winner while idle, registered lock owner otherwise.
   always_comb begin
      lock_oh              = '0;
      lock_oh[lock_id_reg] = 1'b1;
      src_oh               = (state_reg == ST_IDLE) ? grant_idle : lock_oh;
      grant_idx            = '0;
      for (int i = 0; i < NUM; i++) begin
         if (grant_idle[i]) begin
            grant_idx = IDW'(i);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM; gi++) begin : g_mask
         assign data_masked[gi] = src_oh[gi] ? req_data[gi*DW +: DW] : '0;
      end
   endgenerate

   // OR-reduce the masked beats; src_oh is one-hot or zero.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM; i++) begin
         sel_data = sel_data | data_masked[i];
      end
   end

   assign sel_vld  = |(req_vld & src_oh);
   assign sel_last = |(req_last & src_oh);
   assign xfer     = out_vld & out_rdy;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state: lock on a non-last first beat, release on the last beat.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (xfer && !sel_last) state_next = ST_LOCK;
         ST_LOCK: if (xfer && sel_last)  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs: forced quiet while reset is asserted.
   always_comb begin
      out_vld  = rst_b & sel_vld;
      out_last = out_vld & sel_last;
      out_data = out_vld ? sel_data : '0;
      out_src  = out_vld ? src_oh : '0;
      req_rdy  = (out_vld & out_rdy) ? src_oh : '0;
      lock_err = lock_err_reg;
   end

   // Lock owner, saturating beat count and sticky overrun flag.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         lock_id_reg  <= '0;
         beat_cnt_reg <= '0;
         lock_err_reg <= 1'b0;
      end else if (xfer) begin
         if (state_reg == ST_IDLE) begin
            if (!sel_last) begin
               lock_id_reg  <= grant_idx;
               beat_cnt_reg <= CW'(1);
            end
         end else begin
            if (beat_cnt_reg == MAXB_C) begin
               lock_err_reg <= 1'b1;
            end
            if (sel_last) begin
               beat_cnt_reg <= '0;
            end else if (beat_cnt_reg != MAXB_C) begin
               beat_cnt_reg <= beat_cnt_reg + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ct_ciu_burst_arb.sv
// Directed bench for ct_ciu_burst_arb: a vector table for arbitration,
// locking, stalls and bubbles, plus hand sequences for overrun and reset.
module tb_ct_ciu_burst_arb;

   localparam int NUM  = 4;
   localparam int DW   = 16;
   localparam int MAXB = 16;

   logic              clk = 1'b0;
   logic              rst_b;
   logic [NUM-1:0]    req_vld;
   logic [NUM-1:0]    req_last;
   logic [NUM*DW-1:0] req_data;
   logic [NUM-1:0]    req_rdy;
   logic              out_vld;
   logic              out_last;
   logic [DW-1:0]     out_data;
   logic [NUM-1:0]    out_src;
   logic              out_rdy;
   logic              lock_err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] vld;
      logic [3:0] last;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_vld;
      logic [3:0] exp_src;
      logic       exp_last;
   } vec_t;

   vec_t vq[$];

   ct_ciu_burst_arb #(
      .NUM  (NUM),
      .DW   (DW),
      .MAXB (MAXB)
   ) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .req_vld  (req_vld),
      .req_last (req_last),
      .req_data (req_data),
      .req_rdy  (req_rdy),
      .out_vld  (out_vld),
      .out_last (out_last),
      .out_data (out_data),
      .out_src  (out_src),
      .out_rdy  (out_rdy),
      .lock_err (lock_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Requester i carries 0x(i+1)000 | tag so the forwarded source is visible in the data.
   function automatic logic [DW-1:0] pattern(input int i, input int tag);
      return DW'(((i + 1) << 12) | (tag & 'hfff));
   endfunction

   function automatic logic [DW-1:0] exp_data(input logic [3:0] src, input logic vld, input int tag);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < NUM; i++) begin
         if (vld && src[i]) d = pattern(i, tag);
      end
      return d;
   endfunction

   task automatic drive(input logic [3:0] vld, input logic [3:0] last, input logic ordy, input int tag);
      req_vld  = vld;
      req_last = last;
      out_rdy  = ordy;
      for (int i = 0; i < NUM; i++) begin
         req_data[i*DW +: DW] = pattern(i, tag);
      end
   endtask

   task automatic check_outs(input string tn, input int tag, input logic [3:0] e_rdy, input logic e_vld,
                             input logic [3:0] e_src, input logic e_last, input logic e_err);
      chk({tn, ".req_rdy"},  64'(req_rdy),  64'(e_rdy));
      chk({tn, ".out_vld"},  64'(out_vld),  64'(e_vld));
      chk({tn, ".out_src"},  64'(out_src),  64'(e_src));
      chk({tn, ".out_last"}, 64'(out_last), 64'(e_last));
      chk({tn, ".out_data"}, 64'(out_data), 64'(exp_data(e_src, e_vld, tag)));
      chk({tn, ".lock_err"}, 64'(lock_err), 64'(e_err));
      $display("%s: vld=%b last=%b ordy=%b -> rdy=%b ovld=%b src=%b olast=%b data=%h err=%b",
               tn, req_vld, req_last, out_rdy, req_rdy, out_vld, out_src, out_last, out_data, lock_err);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Round robin of single-beat bursts: 0,1,2,3.
      vq.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1});
      vq.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1});
      vq.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1});
      vq.push_back('{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1});
      // Demote 0 and 1 so 2 outranks 0, then a 3-beat burst from 2 with 0 waiting.
      vq.push_back('{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1});
      vq.push_back('{4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1});
      vq.push_back('{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0});
      vq.push_back('{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0});
      vq.push_back('{4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1});
      vq.push_back('{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1});
      // Requester 1 stalled for 5 cycles, then accepted.
      for (int k = 0; k < 5; k++) begin
         vq.push_back('{4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1});
      end
      vq.push_back('{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1});
      // Priority order is now 3,2,0,1: 3 wins the stalled all-valid cycle.
      vq.push_back('{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b1000, 1'b1});
      // Requester 3 locks, bubbles for 2 cycles while 0 waits, then finishes.
      vq.push_back('{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0});
      vq.push_back('{4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0});
      vq.push_back('{4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0});
      vq.push_back('{4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1});
      vq.push_back('{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1});

      // Reset with all requesters valid: outputs must stay quiet.
      rst_b = 1'b0;
      drive(4'b1111, 4'b1111, 1'b1, 0);
      #3;
      check_outs("reset", 0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      step();
      rst_b = 1'b1;

      // Table vectors.
      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].vld, vq[k].last, vq[k].ordy, k + 1);
         #4;
         check_outs($sformatf("vec%0d", k), k + 1, vq[k].exp_rdy, vq[k].exp_vld,
                    vq[k].exp_src, vq[k].exp_last, 1'b0);
         step();
      end

      // Overrun: 18-beat burst from requester 0; flag appears after the 17th transfer.
      for (int k = 1; k <= 18; k++) begin
         drive(4'b0001, (k == 18) ? 4'b0001 : 4'b0000, 1'b1, 100 + k);
         #4;
         check_outs($sformatf("long%0d", k), 100 + k, 4'b0001, 1'b1, 4'b0001,
                    (k == 18), (k >= 18));
         step();
      end
      drive(4'b0000, 4'b0000, 1'b1, 130);
      #4;
      check_outs("long_after", 130, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
      step();

      // Reset in the middle of a locked burst from requester 2.
      drive(4'b0100, 4'b0000, 1'b1, 200);
      #4;
      check_outs("rlock_start", 200, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1);
      step();
      drive(4'b0001, 4'b0000, 1'b1, 201);
      #4;
      check_outs("rlock_hold", 201, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
      #2;
      rst_b = 1'b0;
      drive(4'b1111, 4'b1111, 1'b1, 202);
      #1;
      check_outs("rlock_in_reset", 202, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      step();
      rst_b = 1'b1;
      drive(4'b1111, 4'b1111, 1'b1, 203);
      #4;
      check_outs("rlock_after", 203, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0);
      step();
      drive(4'b1111, 4'b1111, 1'b1, 204);
      #4;
      check_outs("rlock_next", 204, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ct_ciu_burst_arb.md
CT_CIU_BURST_ARB -- requirements
Module: ct_ciu_burst_arb

Interface
REQ-001 Parameter NUM, default 4: number of requesters.
REQ-002 Parameter DW, default 64: beat data width.
REQ-003 Parameter MAXB, default 16: maximum beats per locked burst before the error flag is set.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_b  input  1  asynchronous reset, active-low.
REQ-006 req_vld  input  NUM  per-requester beat valid.
REQ-007 req_last  input  NUM  per-requester last beat of burst.
REQ-008 req_data  input  NUM*DW  per-requester beat data; requester i occupies bits [i*DW +: DW].
REQ-009 req_rdy  output  NUM  per-requester beat accepted this cycle; one-hot or zero.
REQ-010 out_vld  output  1  forwarded beat valid.
REQ-011 out_last  output  1  forwarded last flag.
REQ-012 out_data  output  DW  forwarded data.
REQ-013 out_src  output  NUM  one-hot source of the forwarded beat.
REQ-014 out_rdy  input  1  downstream accepts the beat.
REQ-015 lock_err  output  1  sticky flag: a burst exceeded MAXB beats.

Function
REQ-016 The FSM SHALL have two states: IDLE and LOCK.
REQ-017 In IDLE, the source SHALL be the valid requester chosen by a least-recently-granted matrix; the choice is combinational (zero-cycle arbitration latency).
REQ-018 In LOCK, the source SHALL be the registered lock_id only; other requesters see req_rdy=0.
REQ-019 out_vld = req_vld[src]; out_data, out_last, out_src = the src values; out_src=0 when out_vld=0.
REQ-020 req_rdy[src] = out_vld & out_rdy; all other bits 0. A beat transfers when out_vld & out_rdy.
REQ-021 IDLE->LOCK on a transfer with out_last=0; lock_id <= src; beat_cnt <= 1.
REQ-022 A transfer in IDLE with out_last=1 SHALL keep the FSM in IDLE (single-beat burst).
REQ-023 LOCK->IDLE on a transfer with out_last=1; beat_cnt <= 0.
REQ-024 In LOCK, each non-last transfer increments beat_cnt; beat_cnt saturates at MAXB.
REQ-025 lock_err SHALL set when a transfer in LOCK occurs with beat_cnt==MAXB, and clear only on reset.
REQ-026 The LRU matrix SHALL update only on the first beat of a burst (a transfer in IDLE): the granted requester becomes lowest priority.
REQ-027 LRU state SHALL NOT change during LOCK or on cycles without a transfer.
REQ-028 In IDLE, out_vld & !out_rdy SHALL NOT update state; the selection may change next cycle if the inputs change.
REQ-029 If the locked requester deasserts req_vld in LOCK, out_vld=0 and the FSM stays in LOCK (bubble tolerated).

Reset
REQ-030 On rst_b low: state=IDLE, lock_id=0, beat_cnt=0, lock_err=0, LRU priority = index order (requester 0 highest).
REQ-031 Outputs during reset: req_rdy=0, out_vld=0, out_src=0, out_last=0, out_data=0.
REQ-032 Reset mid-burst SHALL abandon the lock; there is no replay.

Structure
REQ-033 State encodings and the MAXB default SHALL live in a shared ciu arbitration package.
REQ-034 The LRU matrix SHALL be a sub-module instance, ct_prio with NUM=NUM, driven by valid=req_vld gated by state==IDLE and clr=IDLE transfer.
REQ-035 Target size is 120-400 RTL lines.

Verification
REQ-036 After reset, req_vld=4'b1111 with all last=1 and out_rdy=1 for 4 cycles -> grants 0, 1, 2, 3 in that order, lock_err=0.
REQ-037 Requester 2 sends a 3-beat burst (last on beat 3) while requester 0 is valid throughout -> out_src=4'b0100 for 3 transfers, then requester 0 is granted.
REQ-038 Requester 1 holds out_vld with out_rdy=0 for 5 cycles -> no req_rdy, FSM remains IDLE, LRU unchanged; out_rdy=1 -> one transfer.
REQ-039 Locked requester 3 drops req_vld for 2 cycles mid-burst while requester 0 is valid -> out_vld=0 for those 2 cycles, requester 0 is not granted, the burst resumes on requester 3.
REQ-040 Requester 0 sends 18 beats with MAXB=16 -> lock_err rises after the 17th transfer and stays set after last.
REQ-041 rst_b pulsed low during LOCK -> next cycle IDLE, requester 0 has highest priority, all outputs at reset values.
